// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array edge feeder.
package sa_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // Bit position of lane 'lane' inside a flattened N*dw operand bus.
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth delay line for one operand lane: carries {en, data}.
// Every stage clears on reset, so an aborted job leaves nothing behind.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = FP16_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en_in,
    input  logic [DW-1:0] data_in,
    output logic          en_out,
    output logic [DW-1:0] data_out
);

    logic [DW:0] stage [DEPTH];

    // Shift the {en, data} word one stage per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage[s] <= '0;
            end
        end else begin
            stage[0] <= {en_in, data_in};
            for (int s = 1; s < DEPTH; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign {en_out, data_out} = stage[DEPTH-1];

endmodule

// File: rtl/sa_edge_feeder.sv
// Edge sequencer for the FP16 systolic array: takes one operand beat per
// cycle, skews lane i by i extra cycles and sequences a K-step job through
// feed, drain and a one-cycle done pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// FEED  | accepting operand beats until cmd_k have been taken
// DRAIN | flushing skew lines and MAC valid pipeline (N+1 cycles)
// DONE  | done pulse for one cycle, then back to IDLE
module sa_edge_feeder
    import sa_pkg::*;
#(
    parameter int N     = 4,
    parameter int K_MAX = 64,
    parameter int DW    = FP16_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [$clog2(K_MAX+1)-1:0]   cmd_k,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*DW-1:0]              in_a,
    input  logic [N*DW-1:0]              in_b,
    output logic [N*DW-1:0]              row_opA,
    output logic [N-1:0]                 row_enA,
    output logic [N-1:0]                 row_val,
    output logic [N*DW-1:0]              col_opB,
    output logic [N-1:0]                 col_enB,
    output logic                         busy,
    output logic                         done
);

    localparam int KW  = $clog2(K_MAX+1);
    localparam int DCW = $clog2(N+2);

    localparam logic [KW-1:0]  K_ONE       = KW'(1);
    localparam logic [KW-1:0]  K_LIMIT     = KW'(K_MAX);
    localparam logic [DCW-1:0] DRAIN_START = DCW'(N+1);
    localparam logic [DCW-1:0] D_ONE       = DCW'(1);
    localparam logic [DW-1:0]  BUBBLE_DATA = DW'(FP16_ZERO);

    feeder_state_t state;
    logic [KW-1:0]  k_lat;
    logic [KW-1:0]  beat_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           done_q;
    logic           accept;
    logic [KW-1:0]  k_sat;

    assign cmd_ready = (state == IDLE);
    assign in_ready  = (state == FEED);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign done      = done_q;

    // Oversized requests run as K_MAX-step jobs.
    assign k_sat = (cmd_k > K_LIMIT) ? K_LIMIT : cmd_k;

    // Job sequencer: command latch, beat counting, drain timing, done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        beat_cnt <= '0;
                        if (cmd_k == '0) begin
                            // Empty job: no operands, straight to the pulse.
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            k_lat <= k_sat;
                            state <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + K_ONE;
                        if (beat_cnt == k_lat - K_ONE) begin
                            drain_cnt <= DRAIN_START;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == D_ONE) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - D_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-lane skew: lane i gets depth i+1, bubbles carry en=0 and zero data.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_word;
        logic [DW-1:0] b_word;
        logic          en_a;
        logic          en_b;

        assign a_word = accept ? in_a[lane_lsb(i, DW) +: DW] : BUBBLE_DATA;
        assign b_word = accept ? in_b[lane_lsb(i, DW) +: DW] : BUBBLE_DATA;

        sa_skew_line #(
            .DEPTH (i + 1),
            .DW    (DW)
        ) u_skew_a (
            .clk      (clk),
            .reset_n  (reset_n),
            .en_in    (accept),
            .data_in  (a_word),
            .en_out   (en_a),
            .data_out (row_opA[lane_lsb(i, DW) +: DW])
        );

        sa_skew_line #(
            .DEPTH (i + 1),
            .DW    (DW)
        ) u_skew_b (
            .clk      (clk),
            .reset_n  (reset_n),
            .en_in    (accept),
            .data_in  (b_word),
            .en_out   (en_b),
            .data_out (col_opB[lane_lsb(i, DW) +: DW])
        );

        // val_MAC travels with the A operand enable.
        assign row_enA[i] = en_a;
        assign row_val[i] = en_a;
        assign col_enB[i] = en_b;
    end

endmodule

// File: tb/tb_sa_edge_feeder.sv
// Directed bench for sa_edge_feeder: reset abort, back-to-back job, bubbles,
// empty job, ignored commands, special FP16 payloads and k saturation.
module tb_sa_edge_feeder;
    import sa_pkg::*;

    localparam int N     = 4;
    localparam int K_MAX = 64;
    localparam int DW    = 16;
    localparam int KW    = $clog2(K_MAX+1);
    localparam int NR    = 80;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [KW-1:0]     cmd_k = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*DW-1:0]   in_a = '0;
    logic [N*DW-1:0]   in_b = '0;
    logic [N*DW-1:0]   row_opA;
    logic [N-1:0]      row_enA;
    logic [N-1:0]      row_val;
    logic [N*DW-1:0]   col_opB;
    logic [N-1:0]      col_enB;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int data_mode = 0;

    logic [N-1:0]    r_en  [NR];
    logic [N-1:0]    r_val [NR];
    logic [N-1:0]    r_enb [NR];
    logic [N*DW-1:0] r_a   [NR];
    logic [N*DW-1:0] r_b   [NR];
    logic            r_done[NR];
    logic            r_busy[NR];
    logic            r_cmdr[NR];
    logic            r_inr [NR];

    sa_edge_feeder #(.N(N), .K_MAX(K_MAX), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_k     (cmd_k),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .row_opA   (row_opA),
        .row_enA   (row_enA),
        .row_val   (row_val),
        .col_opB   (col_opB),
        .col_enB   (col_enB),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] a_word(input int beat, input int lane);
        logic [DW-1:0] w;
        if (data_mode == 1) begin
            case (lane)
                0:       w = 16'h7E00;
                1:       w = 16'h8000;
                2:       w = 16'h7C00;
                default: w = 16'hFC00;
            endcase
        end else begin
            case (lane)
                0:       w = 16'h3C00;
                1:       w = 16'h4000;
                2:       w = 16'h4200;
                default: w = 16'h4400;
            endcase
            w = w + DW'(beat);
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] b_word(input int beat, input int lane);
        if (data_mode == 1) return a_word(beat, N-1-lane);
        return 16'hC000 + DW'(lane*256 + beat);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input int idx);
        r_en[idx]   = row_enA;
        r_val[idx]  = row_val;
        r_enb[idx]  = col_enB;
        r_a[idx]    = row_opA;
        r_b[idx]    = col_opB;
        r_done[idx] = done;
        r_busy[idx] = busy;
        r_cmdr[idx] = cmd_ready;
        r_inr[idx]  = in_ready;
    endtask

    // Index 1 is the first cycle after the command edge.
    task automatic run_job(input int k, input logic [31:0] vpat, input int hold_last, input int ncyc);
        int  sent;
        logic v;
        logic acc;
        sent = 0;
        cmd_valid = 1'b1;
        cmd_k = KW'(k);
        in_valid = 1'b0;
        tick;
        rec(1);
        for (int c = 1; c < ncyc; c++) begin
            cmd_valid = (c <= hold_last);
            cmd_k = KW'(9);
            v = ((c < 32) ? vpat[c] : 1'b1) && (sent < k);
            in_valid = v;
            for (int i = 0; i < N; i++) begin
                in_a[i*DW +: DW] = v ? a_word(sent, i) : 16'hFFFF;
                in_b[i*DW +: DW] = v ? b_word(sent, i) : 16'hFFFF;
            end
            acc = v && r_inr[c];
            tick;
            rec(c + 1);
            if (acc) sent++;
        end
        cmd_valid = 1'b0;
        in_valid = 1'b0;
        cmd_k = '0;
    endtask

    // mask bit t: a beat was accepted on the edge that opens cycle t.
    task automatic check_lanes(input string tag, input int ncyc, input logic [127:0] mask, input int done_idx);
        for (int c = 1; c <= ncyc; c++) begin
            logic [N-1:0]    ev;
            logic [N*DW-1:0] ea;
            logic [N*DW-1:0] eb;
            ev = '0;
            ea = '0;
            eb = '0;
            for (int i = 0; i < N; i++) begin
                int t;
                int beat;
                t = c - i;
                beat = 0;
                if (t >= 0 && mask[t]) begin
                    for (int u = 0; u < t; u++) if (mask[u]) beat++;
                    ev[i] = 1'b1;
                    ea[i*DW +: DW] = a_word(beat, i);
                    eb[i*DW +: DW] = b_word(beat, i);
                end
            end
            chk($sformatf("%s ctl c%0d", tag, c),
                64'({r_en[c], r_val[c], r_enb[c], r_done[c], r_busy[c], r_cmdr[c]}),
                64'({ev, ev, ev, c == done_idx, c <= done_idx, c > done_idx}));
            chk($sformatf("%s opA c%0d", tag, c), r_a[c], ea);
            chk($sformatf("%s opB c%0d", tag, c), r_b[c], eb);
        end
    endtask

    initial begin
        int dcount;
        int ecount;

        // Reset state
        #12;
        chk("rst opA", row_opA, 64'h0);
        chk("rst opB", col_opB, 64'h0);
        chk("rst ctl", 64'({row_enA, row_val, col_enB, done, busy, in_ready, cmd_ready}), 64'h1);
        @(negedge clk);
        reset_n = 1'b1;
        tick;

        // Reset mid-FEED after 2 of 5 beats
        data_mode = 0;
        cmd_valid = 1'b1;
        cmd_k = KW'(5);
        tick;
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) in_a[i*DW +: DW] = a_word(0, i);
        tick;
        for (int i = 0; i < N; i++) in_a[i*DW +: DW] = a_word(1, i);
        tick;
        chk("midjob feed", 64'({busy, in_ready, cmd_ready, row_enA[0]}), 64'b1101);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("abort opA", row_opA, 64'h0);
        chk("abort opB", col_opB, 64'h0);
        chk("abort ctl", 64'({row_enA, row_val, col_enB, done, busy, in_ready, cmd_ready}), 64'h1);
        tick;
        tick;
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        ecount = 0;
        repeat (10) begin
            tick;
            if (done) dcount++;
            if (row_enA != '0 || col_enB != '0) ecount++;
        end
        chk("abort no done", 64'(dcount), 64'd0);
        chk("abort no en", 64'(ecount), 64'd0);

        // k=3 back-to-back
        run_job(3, 32'hFFFF_FFFE, 0, 14);
        check_lanes("A", 14, 128'h1C, 9);
        chk("A enA0 first", 64'(r_en[2][0]), 64'd1);
        chk("A enA3 first", 64'(r_en[5][3]), 64'd1);
        chk("A enA3 last", 64'(r_en[7][3]), 64'd1);
        chk("A enA3 after", 64'(r_en[8][3]), 64'd0);
        chk("A opA3", 64'(r_a[5][63:48]), 64'h4400);
        chk("A opA0 beat2", 64'(r_a[4][15:0]), 64'h3C02);
        chk("A in_ready feed", 64'(r_inr[3]), 64'd1);
        chk("A in_ready drain", 64'(r_inr[4]), 64'd0);
        chk("A done", 64'(r_done[9]), 64'd1);

        // k=4 with a 2-cycle bubble after beat 2
        run_job(4, 32'hFFFF_FFE6, 0, 16);
        check_lanes("B", 16, 128'hCC, 12);
        chk("B gap en0", 64'(r_en[4][0]), 64'd0);
        chk("B gap data0", 64'(r_a[4][15:0]), 64'h0);
        chk("B gap en3", 64'(r_en[7][3]), 64'd0);
        chk("B resume en3", 64'(r_en[9][3]), 64'd1);
        chk("B done", 64'(r_done[12]), 64'd1);

        // k=0
        run_job(0, 32'h0, 0, 8);
        check_lanes("C", 8, 128'h0, 1);
        chk("C busy", 64'({r_busy[1], r_busy[2]}), 64'b10);

        // cmd_valid held through FEED, DRAIN and DONE
        run_job(2, 32'hFFFF_FFFE, 8, 12);
        check_lanes("D", 12, 128'hC, 8);
        chk("D cmd_ready", 64'(r_cmdr[4]), 64'd0);

        // NaN / -0 / Inf payloads
        data_mode = 1;
        run_job(2, 32'hFFFF_FFFE, 0, 12);
        check_lanes("E", 12, 128'hC, 8);
        chk("E nan", 64'(r_a[2][15:0]), 64'h7E00);
        chk("E negzero", 64'(r_a[3][31:16]), 64'h8000);
        chk("E inf", 64'(r_a[4][47:32]), 64'h7C00);
        chk("E b lane0", 64'(r_b[2][15:0]), 64'hFC00);
        chk("E b lane3", 64'(r_b[5][63:48]), 64'h7E00);

        // cmd_k above K_MAX saturates to K_MAX
        data_mode = 0;
        run_job(127, 32'hFFFF_FFFE, 0, 74);
        check_lanes("F", 74, ((128'd1 << 64) - 128'd1) << 2, 70);
        chk("F last en0", 64'({r_en[65][0], r_en[66][0]}), 64'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
